// File: rtl/hy_riscv_exec_core.sv
// Multi-cycle RV32I execute core: IDLE/EXEC/MEM FSM, own register file, req/ack memory port.
// Define HY_RV_M_EXT_EN to add single-cycle MUL/MULH/MULHSU/MULHU.
module hy_riscv_exec_core #(
    parameter int NUM_REGS = 32,
    parameter int MEM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [31:0]       opcode,
    input  logic [31:0]       op_pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              retire_valid,
    output logic [31:0]       alu_result,
    output logic              branch_taken,
    output logic [31:0]       branch_target,
    output logic              illegal
);

    localparam int         IW = $clog2(NUM_REGS);
    localparam logic [5:0] NR = 6'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] a, b, ea, pc4;
    logic        rs1_ok, rs2_ok, rd_ok;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic        is_load, is_store, is_opimm, is_op;

    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'd0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_br    = opc == 7'b1100011;
    assign is_load  = opc == 7'b0000011;
    assign is_store = opc == 7'b0100011;
    assign is_opimm = opc == 7'b0010011;
    assign is_op    = opc == 7'b0110011;

    assign rs1_ok = {1'b0, rs1} < NR;
    assign rs2_ok = {1'b0, rs2} < NR;
    assign rd_ok  = {1'b0, rd} < NR;

    assign a   = rs1_ok ? regs[rs1[IW-1:0]] : 32'd0;
    assign b   = rs2_ok ? regs[rs2[IW-1:0]] : 32'd0;
    assign pc4 = pc + 32'd4;
    assign ea  = a + (is_store ? imm_s : imm_i);

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
        logic [31:0] sra;
        sra = $signed(x) >>> y[4:0];
        unique case (f)
            3'b000:  alu = alt ? x - y : x + y;
            3'b001:  alu = x << y[4:0];
            3'b010:  alu = {31'd0, $signed(x) < $signed(y)};
            3'b011:  alu = {31'd0, x < y};
            3'b100:  alu = x ^ y;
            3'b101:  alu = alt ? sra : x >> y[4:0];
            3'b110:  alu = x | y;
            default: alu = x & y;
        endcase
    endfunction

`ifdef HY_RV_M_EXT_EN
    logic [32:0] ma, mb;
    logic [63:0] prod;
    logic [31:0] mul_res;
    assign ma      = {(f3 == 3'b001 || f3 == 3'b010) ? a[31] : 1'b0, a};
    assign mb      = {(f3 == 3'b001) ? b[31] : 1'b0, b};
    assign prod    = $signed({{31{ma[32]}}, ma}) * $signed({{31{mb[32]}}, mb});
    assign mul_res = (f3 == 3'b000) ? prod[31:0] : prod[63:32];
`endif

    logic        ill, wb, taken, is_mem, we, cond, use1, use2, use_d;
    logic [31:0] res, target, wdata, ld_val;
    logic [3:0]  strb;
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        ill    = 1'b0;
        wb     = 1'b0;
        taken  = 1'b0;
        is_mem = 1'b0;
        we     = 1'b0;
        cond   = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        use_d  = 1'b0;
        res    = 32'd0;
        target = pc4;
        wdata  = 32'd0;
        strb   = 4'd0;
        unique case (1'b1)
            is_lui: begin
                res = imm_u; wb = 1'b1; use_d = 1'b1;
            end
            is_auipc: begin
                res = pc + imm_u; wb = 1'b1; use_d = 1'b1;
            end
            is_jal: begin
                res = pc4; wb = 1'b1; use_d = 1'b1;
                taken = 1'b1; target = pc + imm_j;
            end
            is_jalr: begin
                res = pc4; wb = 1'b1; use1 = 1'b1; use_d = 1'b1;
                taken = 1'b1; target = (a + imm_i) & ~32'd1;
                ill = f3 != 3'b000;
            end
            is_br: begin
                use1 = 1'b1; use2 = 1'b1;
                case (f3)
                    3'b000:  cond = a == b;
                    3'b001:  cond = a != b;
                    3'b100:  cond = $signed(a) < $signed(b);
                    3'b101:  cond = $signed(a) >= $signed(b);
                    3'b110:  cond = a < b;
                    3'b111:  cond = a >= b;
                    default: ill = 1'b1;
                endcase
                res   = {31'd0, cond};
                taken = cond;
                if (cond) target = pc + imm_b;
            end
            is_load: begin
                use1 = 1'b1; use_d = 1'b1; is_mem = 1'b1; res = ea;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11)
                   || (f3[1:0] == 2'b01 && ea[0])
                   || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);
            end
            is_store: begin
                use1 = 1'b1; use2 = 1'b1; is_mem = 1'b1; we = 1'b1; res = ea;
                case (f3)
                    3'b000: begin strb = 4'b0001 << ea[1:0]; wdata = {4{b[7:0]}}; end
                    3'b001: begin strb = 4'b0011 << ea[1:0]; wdata = {2{b[15:0]}}; end
                    3'b010: begin strb = 4'b1111; wdata = b; end
                    default: ill = 1'b1;
                endcase
                if ((f3 == 3'b001 && ea[0]) || (f3 == 3'b010 && ea[1:0] != 2'b00))
                    ill = 1'b1;
            end
            is_opimm: begin
                use1 = 1'b1; use_d = 1'b1; wb = 1'b1;
                res = alu(f3, f3 == 3'b101 && f7[5], a, imm_i);
                ill = (f3 == 3'b001 && f7 != 7'd0)
                   || (f3 == 3'b101 && f7 != 7'd0 && f7 != 7'b0100000);
            end
            is_op: begin
                use1 = 1'b1; use2 = 1'b1; use_d = 1'b1; wb = 1'b1;
                if (f7 == 7'd0)
                    res = alu(f3, 1'b0, a, b);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    res = alu(f3, 1'b1, a, b);
`ifdef HY_RV_M_EXT_EN
                else if (f7 == 7'b0000001 && !f3[2])
                    res = mul_res;
`endif
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if ((use1 && !rs1_ok) || (use2 && !rs2_ok) || (use_d && !rd_ok))
            ill = 1'b1;
        if (ill) begin
            wb = 1'b0; is_mem = 1'b0; taken = 1'b0; target = pc4;
        end
    end

    assign lb = mem_rdata[{ea[1:0], 3'b000} +: 8];
    assign lh = mem_rdata[{ea[1], 4'b0000} +: 16];

    always_comb begin
        case (f3)
            3'b000:  ld_val = {{24{lb[7]}}, lb};
            3'b100:  ld_val = {24'd0, lb};
            3'b001:  ld_val = {{16{lh[15]}}, lh};
            3'b101:  ld_val = {16'd0, lh};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_ready      <= 1'b0;
            ir            <= 32'd0;
            pc            <= 32'd0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            mem_wstrb     <= 4'd0;
            retire_valid  <= 1'b0;
            alu_result    <= 32'd0;
            branch_taken  <= 1'b0;
            branch_target <= 32'd0;
            illegal       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
        end else begin
            retire_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        ir       <= opcode;
                        pc       <= op_pc;
                        op_ready <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= we;
                        mem_addr  <= ea[MEM_AW+1:2];
                        mem_wdata <= wdata;
                        mem_wstrb <= strb;
                        state     <= MEM;
                    end else begin
                        if (wb && rd != 5'd0) regs[rd[IW-1:0]] <= res;
                        retire_valid  <= 1'b1;
                        alu_result    <= res;
                        branch_taken  <= taken;
                        branch_target <= target;
                        illegal       <= ill;
                        op_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    if (mem_ack) begin
                        if (!mem_we && rd != 5'd0) regs[rd[IW-1:0]] <= ld_val;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_wstrb     <= 4'd0;
                        retire_valid  <= 1'b1;
                        alu_result    <= mem_we ? ea : ld_val;
                        branch_taken  <= 1'b0;
                        branch_target <= pc4;
                        illegal       <= 1'b0;
                        op_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hy_riscv_exec_core.sv
// Directed bench for hy_riscv_exec_core (NUM_REGS=16): vector table plus
// hand sequences for memory wait states and reset during a pending load.
module tb_hy_riscv_exec_core;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] opcode;
    logic [31:0] op_pc;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        retire_valid;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal;

    hy_riscv_exec_core #(.NUM_REGS(16), .MEM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .op_pc(op_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .retire_valid(retire_valid), .alu_result(alu_result),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] res;
        logic        tk;
        logic [31:0] tgt;
        logic        ill;
        int          lat;
        int          reqs;
    } vec_t;

    function automatic vec_t v(input logic [31:0] ins, input logic [31:0] pc,
                               input int dly, input logic [31:0] rdata,
                               input logic [31:0] res, input logic tk,
                               input logic [31:0] tgt, input logic ill,
                               input int lat, input int reqs);
        vec_t r;
        r.ins = ins; r.pc = pc; r.dly = dly; r.rdata = rdata; r.res = res;
        r.tk = tk; r.tgt = tgt; r.ill = ill; r.lat = lat; r.reqs = reqs;
        return r;
    endfunction

    logic        r_done, r_tk, r_ill, r_rdy_at, r_rdy_early, r_stable;
    logic [31:0] r_res, r_tgt;
    int          r_lat, r_reqs;
    logic        m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    // Offer one instruction at a negedge, ack the dly-th request cycle, capture retire.
    task automatic run(input logic [31:0] ins, input logic [31:0] pc,
                       input int dly, input logic [31:0] rdata);
        int w;
        int cyc;
        opcode = ins; op_pc = pc; mem_rdata = rdata; op_valid = 1'b1;
        w = 0;
        while (!op_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 1; r_reqs = 0; r_done = 1'b0;
        r_rdy_early = 1'b0; r_stable = 1'b1;
        while (!r_done && cyc < 40) begin
            if (retire_valid) begin
                r_done = 1'b1; r_res = alu_result; r_tk = branch_taken;
                r_tgt = branch_target; r_ill = illegal; r_rdy_at = op_ready;
            end else begin
                if (op_ready) r_rdy_early = 1'b1;
                if (mem_req) begin
                    if (r_reqs == 0) begin
                        m_we = mem_we; m_addr = mem_addr;
                        m_wdata = mem_wdata; m_wstrb = mem_wstrb;
                    end else if (m_we !== mem_we || m_addr !== mem_addr ||
                                 m_wdata !== mem_wdata || m_wstrb !== mem_wstrb) begin
                        r_stable = 1'b0;
                    end
                    r_reqs++;
                    mem_ack = (r_reqs >= dly);
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        r_lat = cyc;
        chk("retired", 0, {31'd0, r_done}, 32'd1);
    endtask

    vec_t vecs [30];

    initial begin
        reset = 1'b1; op_valid = 1'b0; opcode = 32'd0; op_pc = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        vecs[0]  = v(32'h00500093, 32'h0,   1, 32'h0, 32'h5,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[1]  = v(32'h00108133, 32'h0,   1, 32'h0, 32'hA,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[2]  = v(32'h00700013, 32'h0,   1, 32'h0, 32'h7,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[3]  = v(32'h00000033, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[4]  = v(32'h00000203, 32'h0,   1, 32'hF0, 32'hFFFFFFF0, 1'b0, 32'h4,  1'b0, 3, 1);
        vecs[5]  = v(32'h00020033, 32'h0,   1, 32'h0, 32'hFFFFFFF0, 1'b0, 32'h4,   1'b0, 2, 0);
        vecs[6]  = v(32'h00004203, 32'h0,   2, 32'hF0, 32'hF0,      1'b0, 32'h4,   1'b0, 4, 2);
        vecs[7]  = v(32'h00020033, 32'h0,   1, 32'h0, 32'hF0,       1'b0, 32'h4,   1'b0, 2, 0);
        vecs[8]  = v(32'h00108863, 32'h100, 1, 32'h0, 32'h1,        1'b1, 32'h110, 1'b0, 2, 0);
        vecs[9]  = v(32'h00109863, 32'h100, 1, 32'h0, 32'h0,        1'b0, 32'h104, 1'b0, 2, 0);
        vecs[10] = v(32'h00202183, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
        vecs[11] = v(32'h00100A13, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
        vecs[12] = v(32'h003A0093, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
        vecs[13] = v(32'h00008033, 32'h0,   1, 32'h0, 32'h5,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[14] = v(32'h008002EF, 32'h200, 1, 32'h0, 32'h204,      1'b1, 32'h208, 1'b0, 2, 0);
        vecs[15] = v(32'h00508367, 32'h300, 1, 32'h0, 32'h304,      1'b1, 32'hA,   1'b0, 2, 0);
        vecs[16] = v(32'h402083B3, 32'h0,   1, 32'h0, 32'hFFFFFFFB, 1'b0, 32'h4,   1'b0, 2, 0);
        vecs[17] = v(32'h4013D413, 32'h0,   1, 32'h0, 32'hFFFFFFFD, 1'b0, 32'h4,   1'b0, 2, 0);
        vecs[18] = v(32'h0070B4B3, 32'h0,   1, 32'h0, 32'h1,        1'b0, 32'h4,   1'b0, 2, 0);
        vecs[19] = v(32'h0070A4B3, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b0, 2, 0);
`ifdef HY_RV_M_EXT_EN
        vecs[20] = v(32'h02208533, 32'h0,   1, 32'h0, 32'h32,       1'b0, 32'h4,   1'b0, 2, 0);
`else
        vecs[20] = v(32'h02208533, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
`endif
        vecs[21] = v(32'h0220C533, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
        vecs[22] = v(32'hFFFFFFFF, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);
        vecs[23] = v(32'h123455B7, 32'h0,   1, 32'h0, 32'h12345000, 1'b0, 32'h4,   1'b0, 2, 0);
        vecs[24] = v(32'h00001617, 32'h400, 1, 32'h0, 32'h1400,     1'b0, 32'h404, 1'b0, 2, 0);
        vecs[25] = v(32'h00201683, 32'h0,   1, 32'h80010000, 32'hFFFF8001, 1'b0, 32'h4, 1'b0, 3, 1);
        vecs[26] = v(32'h00028033, 32'h0,   1, 32'h0, 32'h204,      1'b0, 32'h4,   1'b0, 2, 0);
        vecs[27] = v(32'h0013C463, 32'h500, 1, 32'h0, 32'h1,        1'b1, 32'h508, 1'b0, 2, 0);
        vecs[28] = v(32'h0013F463, 32'h500, 1, 32'h0, 32'h1,        1'b1, 32'h508, 1'b0, 2, 0);
        vecs[29] = v(32'h40109093, 32'h0,   1, 32'h0, 32'h0,        1'b0, 32'h4,   1'b1, 2, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", 0, {31'd0, op_ready}, 32'd0);
        chk("rst_mem_req", 0, {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", 0, {31'd0, mem_we}, 32'd0);
        chk("rst_wstrb", 0, {28'd0, mem_wstrb}, 32'd0);
        chk("rst_retire", 0, {31'd0, retire_valid}, 32'd0);
        chk("rst_flags", 0, {30'd0, illegal, branch_taken}, 32'd0);
        chk("rst_alu", 0, alu_result, 32'd0);
        chk("rst_target", 0, branch_target, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_op_ready", 0, {31'd0, op_ready}, 32'd1);

        for (int i = 0; i < 30; i++) begin
            run(vecs[i].ins, vecs[i].pc, vecs[i].dly, vecs[i].rdata);
            if (!vecs[i].ill) chk("alu_result", i, r_res, vecs[i].res);
            chk("branch_taken", i, {31'd0, r_tk}, {31'd0, vecs[i].tk});
            chk("branch_target", i, r_tgt, vecs[i].tgt);
            chk("illegal", i, {31'd0, r_ill}, {31'd0, vecs[i].ill});
            chk("latency", i, r_lat, vecs[i].lat);
            chk("mem_req_cycles", i, r_reqs, vecs[i].reqs);
            chk("ready_at_retire", i, {31'd0, r_rdy_at}, 32'd1);
            chk("ready_while_busy", i, {31'd0, r_rdy_early}, 32'd0);
        end

        // SW x2,8(x0) with x2=10, ack in third request cycle
        run(32'h00202423, 32'h0, 3, 32'h0);
        chk("sw_alu", 0, r_res, 32'h8);
        chk("sw_lat", 0, r_lat, 5);
        chk("sw_reqs", 0, r_reqs, 3);
        chk("sw_stable", 0, {31'd0, r_stable}, 32'd1);
        chk("sw_ready_busy", 0, {31'd0, r_rdy_early}, 32'd0);
        chk("sw_we", 0, {31'd0, m_we}, 32'd1);
        chk("sw_addr", 0, {22'd0, m_addr}, 32'd2);
        chk("sw_wstrb", 0, {28'd0, m_wstrb}, 32'hF);
        chk("sw_wdata", 0, m_wdata, 32'hA);

        // SB x2,3(x0)
        run(32'h002001A3, 32'h0, 1, 32'h0);
        chk("sb_alu", 0, r_res, 32'h3);
        chk("sb_addr", 0, {22'd0, m_addr}, 32'd0);
        chk("sb_wstrb", 0, {28'd0, m_wstrb}, 32'h8);
        chk("sb_wdata", 0, m_wdata, 32'h0A0A0A0A);

        // SH x2,2(x0)
        run(32'h00201123, 32'h0, 1, 32'h0);
        chk("sh_wstrb", 0, {28'd0, m_wstrb}, 32'hC);
        chk("sh_wdata", 0, m_wdata, 32'h000A000A);
        chk("sh_we", 0, {31'd0, m_we}, 32'd1);

        // Reset while LW x3,0(x0) waits for an ack that never comes
        opcode = 32'h00002183; op_pc = 32'h0; op_valid = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("pend_mem_req", 0, {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 0, {31'd0, mem_req}, 32'd0);
        chk("abort_retire", 0, {31'd0, retire_valid}, 32'd0);
        chk("abort_ready", 0, {31'd0, op_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rel_ready", 0, {31'd0, op_ready}, 32'd1);
        chk("abort_rel_retire", 0, {31'd0, retire_valid}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            run(32'h00000033 | (32'(i) << 15), 32'h0, 1, 32'h0);
            chk("reg_after_reset", i, r_res, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hy_riscv_exec_core.md
# hy_riscv_exec_core

Parametrised multi-cycle RV32I execute core, successor to the single-cycle CPU block. It accepts one instruction at a time over a valid/ready handshake, decodes and executes it internally, and owns an NUM_REGS-entry register file. Loads and stores go out on a request/acknowledge memory port that tolerates variable latency and supports byte and halfword accesses. It reports every retired instruction together with its branch outcome and an illegal-instruction flag.

## Interface
- NUM_REGS, 32: register count; 16 (RV32E) or 32; x0 hardwired to zero.
- MEM_AW, 10: word-address width of the memory port.
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- op_valid  in  1  instruction offered.
- op_ready  out  1  core idle; accepts when op_valid & op_ready.
- opcode  in  32  instruction word.
- op_pc  in  32  PC of the offered instruction.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  MEM_AW  word address = effective address[MEM_AW+1:2].
- mem_wdata  out  32  store data, lane-aligned.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  request completes on the cycle it is sampled high with mem_req.
- mem_rdata  in  32  load word; valid with mem_ack.
- retire_valid  out  1  one-cycle pulse per retired instruction.
- alu_result  out  32  value computed for rd. For stores, the effective address. For branches, the compare result (0/1).
- branch_taken  out  1  taken branch, JAL or JALR.
- branch_target  out  32  redirect PC; op_pc+4 when not taken.
- illegal  out  1  qualifies retire_valid: instruction rejected.

## Operation
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP.
- FSM states: IDLE, EXEC, MEM.
  - IDLE: op_ready=1. On handshake, capture opcode and op_pc, then go to EXEC.
  - EXEC: read operands, compute the ALU result, effective address and branch outcome.
  - From EXEC, load/store go to MEM; all other instructions retire and return to IDLE.
  - MEM: mem_req=1, with all mem_* outputs stable. On mem_ack, retire and return to IDLE.
- Retire actions:
  - Write rd (writes to x0 are discarded).
  - Register alu_result, branch_taken, branch_target and illegal.
  - Pulse retire_valid.
- Loads: select the byte or halfword lane from mem_rdata using address bits [1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Stores: replicate data across lanes. mem_wstrb is 0001<<a[1:0] for SB, 0011<<a[1:0] for SH, 1111 for SW.
- JAL and JALR write op_pc+4 to rd. JALR target is (rs1+imm) & ~1. Branch and JAL targets are op_pc+imm.
- Shifts use shamt = opcode[24:20]; SRAI/SRA when funct7 = 0100000.
- All arithmetic is 32-bit wrap-around. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- An instruction is illegal when any of the following holds:
  - unknown opcode, funct3 or funct7;
  - rs1, rs2 or rd is ≥ NUM_REGS;
  - LH/LHU/SH with address[0]=1;
  - LW/SW with address[1:0]≠0.
- An illegal instruction retires from EXEC with illegal=1: no register write, no mem_req, branch_taken=0, branch_target=op_pc+4.

## Timing
- Reset values:
  - op_ready=0 while reset is high, 1 in the first cycle after release;
  - mem_req=0, mem_we=0, mem_wstrb=0;
  - retire_valid=0, illegal=0, branch_taken=0;
  - alu_result=0, branch_target=0;
  - all registers 0; state IDLE.
- Non-memory instruction accepted at edge E0:
  - EXEC during cycle E0→E1;
  - retire_valid high in cycle E1→E2, simultaneously with op_ready=1.
  - Throughput: one instruction per 2 cycles.
- Memory instruction: mem_req rises after E1 and stays high through the cycle in which mem_ack is sampled.
  - At that edge: retire, mem_req=0, load data written.
  - With mem_ack already high in the first request cycle, retire_valid comes 3 cycles after acceptance.
- mem_ack while mem_req=0 is ignored.
- Result outputs hold their last retired values until the next retire.
- The register written at a retire is visible to the next accepted instruction; no hazard is possible.
- Reset mid-operation: the next edge abandons the instruction. mem_req drops to 0 and nothing retires.

## Configuration
- HY_RV_M_EXT_EN defined:
  - OP with funct7=0000001 and funct3 000/001/010/011 executes MUL/MULH/MULHSU/MULHU in EXEC (single cycle);
  - funct3 1xx (divide) is illegal.
- HY_RV_M_EXT_EN undefined: every funct7=0000001 OP is illegal and no multiplier is synthesised.

## Test plan
- ADDI x1,x0,5 (0x00500093), then ADD x2,x1,x1 (0x00108133):
  - retire pulses with alu_result 5, then 10;
  - ADDI x0,x0,7 gives alu_result 7 and x0 stays 0.
- SW x2,8(x0) (0x00202423) with x2=10 and mem_ack delayed 3 cycles:
  - mem_req high for 3 cycles with mem_addr=2, mem_wstrb=1111, mem_wdata=10;
  - op_ready=0 until retire.
- mem_rdata=0x000000F0:
  - LB x4,0(x0) (0x00000203) → x4=0xFFFFFFF0;
  - LBU (0x00004203) → x4=0x000000F0.
- op_pc=0x100, BEQ x1,x1,+16 (0x00108863) → branch_taken=1, branch_target=0x110.
  - With NUM_REGS=16, any instruction using x20 → illegal=1 and no register change.
- LW x3,2(x0) (0x00202183) → retire with illegal=1 two cycles after accept; mem_req never asserted.
- Reset asserted during a pending load (mem_req=1, mem_ack=0):
  - next cycle mem_req=0 and no retire;
  - after release, op_ready=1 and all registers read 0.
